// File: rtl/centroid_scan_if.sv
// Pixel fetch bus between the centroid scanner (master) and the image store (slave).
// Handshake: master holds req_valid and a stable req_adr until a cycle where rec_data_vaild=1 (rec_data qualified by it).
interface centroid_scan_if #(
    parameter int AW = 10
) ();
    logic [AW-1:0] req_adr_x;
    logic [AW-1:0] req_adr_y;
    logic          req_valid;
    logic          rec_data;
    logic          rec_data_vaild;

    modport master (
        output req_adr_x, req_adr_y, req_valid,
        input  rec_data, rec_data_vaild
    );

    modport slave (
        input  req_adr_x, req_adr_y, req_valid,
        output rec_data, rec_data_vaild
    );
endinterface

// File: rtl/centroid_scan.sv
// Scans a (2*HALF+1)^2 window around an approximate centre, fetches one pixel per position,
// and returns the half-up rounded centroid of the hit pixels via a restoring divider.
module centroid_scan #(
    parameter int AW      = 10,
    parameter int HALF    = 10,
    parameter int MIN_PTS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [AW-1:0]        app_adr_x,
    input  logic [AW-1:0]        app_adr_y,
    centroid_scan_if.master      pix,
    output logic                 coc_valid,
    output logic [AW-1:0]        coc_adr_x,
    output logic [AW-1:0]        coc_adr_y,
    output logic                 error,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int N  = (2*HALF+1)*(2*HALF+1);
    localparam int CW = $clog2(N+1);
    localparam int SW = AW + $clog2(N);
    localparam int PW = AW + 2;
    localparam int DW = $clog2(2*HALF+2);
    localparam int KW = $clog2(SW+1);
    localparam logic [DW-1:0] LAST_CNT = DW'(2*HALF);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_PTS);
    localparam logic [KW-1:0] DIV_LAST = KW'(SW-1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    // Positions are two's complement with one spare bit so x0+2*HALF never wraps.
    logic [PW-1:0] x0, pos_x, pos_y;
    logic [DW-1:0] cnt_x, cnt_y;
    logic [SW-1:0] acc_x, acc_y;
    logic [CW-1:0] hits, rem_x, rem_y;
    logic [KW-1:0] div_cnt;
    logic          err_flag;

    logic          in_range, req_on, accept, hit, step, last_pos;
    logic [CW-1:0] hits_nx;
    logic [PW-1:0] start_x, start_y;
    logic [CW+SW-1:0] st_x, st_y;

    // One restoring-division step; acc holds the dividend shifting out and the quotient shifting in.
    function automatic logic [CW+SW-1:0] div_step(input logic [CW-1:0] rem,
                                                  input logic [SW-1:0] q,
                                                  input logic [CW-1:0] d);
        logic [CW:0] sh;
        logic        ge;
        sh = {rem, q[SW-1]};
        ge = (sh >= {1'b0, d});
        if (ge) sh = sh - {1'b0, d};
        return {sh[CW-1:0], q[SW-2:0], ge};
    endfunction

    function automatic logic [AW-1:0] round_q(input logic [CW+SW-1:0] st,
                                              input logic [CW-1:0] d);
        logic [CW:0] r2;
        r2 = {st[CW+SW-1:SW], 1'b0};
        return st[AW-1:0] + {{(AW-1){1'b0}}, (r2 >= {1'b0, d})};
    endfunction

    always_comb begin
        in_range = (pos_x[PW-1:AW] == 2'b00) && (pos_y[PW-1:AW] == 2'b00);
        req_on   = (state == SCAN) && in_range;
        accept   = req_on && pix.rec_data_vaild;
        hit      = accept && pix.rec_data;
        step     = (state == SCAN) && (accept || !in_range);
        last_pos = (cnt_x == LAST_CNT) && (cnt_y == LAST_CNT);
        hits_nx  = hits + {{(CW-1){1'b0}}, hit};
        start_x  = {2'b00, app_adr_x} - PW'(HALF);
        start_y  = {2'b00, app_adr_y} - PW'(HALF);
        st_x     = div_step(rem_x, acc_x, hits);
        st_y     = div_step(rem_y, acc_y, hits);
    end

    assign pix.req_valid = req_on;
    assign pix.req_adr_x = pos_x[AW-1:0];
    assign pix.req_adr_y = pos_y[AW-1:0];
    assign coc_valid     = (state == DONE);
    assign error         = (state == DONE) && err_flag;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x0        <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            cnt_x     <= '0;
            cnt_y     <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            hits      <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            div_cnt   <= '0;
            err_flag  <= 1'b0;
            coc_adr_x <= '0;
            coc_adr_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        x0    <= start_x;
                        pos_x <= start_x;
                        pos_y <= start_y;
                        cnt_x <= '0;
                        cnt_y <= '0;
                        acc_x <= '0;
                        acc_y <= '0;
                        hits  <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        acc_x <= acc_x + {{(SW-AW){1'b0}}, pos_x[AW-1:0]};
                        acc_y <= acc_y + {{(SW-AW){1'b0}}, pos_y[AW-1:0]};
                        hits  <= hits_nx;
                    end
                    if (step) begin
                        if (last_pos) begin
                            rem_x   <= '0;
                            rem_y   <= '0;
                            div_cnt <= '0;
                            if (hits_nx < MIN_C) begin
                                err_flag <= 1'b1;
                                state    <= DONE;
                            end else begin
                                err_flag <= 1'b0;
                                state    <= DIV;
                            end
                        end else if (cnt_x == LAST_CNT) begin
                            cnt_x <= '0;
                            pos_x <= x0;
                            cnt_y <= cnt_y + DW'(1);
                            pos_y <= pos_y + PW'(1);
                        end else begin
                            cnt_x <= cnt_x + DW'(1);
                            pos_x <= pos_x + PW'(1);
                        end
                    end
                end
                DIV: begin
                    {rem_x, acc_x} <= st_x;
                    {rem_y, acc_y} <= st_y;
                    div_cnt        <= div_cnt + KW'(1);
                    if (div_cnt == DIV_LAST) begin
                        coc_adr_x <= round_q(st_x, hits);
                        coc_adr_y <= round_q(st_y, hits);
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_centroid_scan.sv
// Directed bench for centroid_scan with AW=10, HALF=2, MIN_PTS=1 (N=25, SW=15).
module tb_centroid_scan;
    localparam int AW = 10;
    localparam int HALF = 2;
    localparam int MIN_PTS = 1;

    typedef struct {
        logic [AW-1:0] ax, ay;
        bit            all;
        int            nh;
        logic [AW-1:0] h0x, h0y, h1x, h1y, h2x, h2y;
        int            dly;
        bit            noise;
        logic [AW-1:0] ex, ey;
        bit            eerr;
        int            elat;
        int            ereq;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] app_x = '0;
    logic [AW-1:0] app_y = '0;
    logic          coc_valid, error, busy;
    logic [AW-1:0] coc_x, coc_y;
    logic [1:0]    dbg_state;

    centroid_scan_if #(.AW(AW)) pix ();

    centroid_scan #(.AW(AW), .HALF(HALF), .MIN_PTS(MIN_PTS)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .app_adr_x(app_x), .app_adr_y(app_y),
        .pix(pix),
        .coc_valid(coc_valid), .coc_adr_x(coc_x), .coc_adr_y(coc_y),
        .error(error), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[7];

    bit            cur_all = 1'b0;
    bit            cur_noise = 1'b0;
    int            cur_nh = 0;
    int            cur_dly = 0;
    logic [AW-1:0] hx[3];
    logic [AW-1:0] hy[3];
    int            acc_cnt = 0;
    logic [2*AW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [AW-1:0] ax, ay, input bit all, input int nh,
                                input logic [AW-1:0] h0x, h0y, h1x, h1y, h2x, h2y,
                                input int dly, input bit noise,
                                input logic [AW-1:0] ex, ey, input bit eerr,
                                input int elat, ereq);
        vec_t v;
        v.ax = ax; v.ay = ay; v.all = all; v.nh = nh;
        v.h0x = h0x; v.h0y = h0y; v.h1x = h1x; v.h1y = h1y; v.h2x = h2x; v.h2y = h2y;
        v.dly = dly; v.noise = noise; v.ex = ex; v.ey = ey; v.eerr = eerr;
        v.elat = elat; v.ereq = ereq;
        return v;
    endfunction

    function automatic bit is_hit(input logic [AW-1:0] x, y);
        if (cur_all) return 1'b1;
        for (int k = 0; k < cur_nh; k++)
            if (hx[k] == x && hy[k] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_mode(input vec_t v);
        cur_all = v.all; cur_nh = v.nh; cur_dly = v.dly; cur_noise = v.noise;
        hx[0] = v.h0x; hy[0] = v.h0y;
        hx[1] = v.h1x; hy[1] = v.h1y;
        hx[2] = v.h2x; hy[2] = v.h2y;
    endtask

    task automatic build_exp(input logic [AW-1:0] ax, ay);
        int x, y;
        for (int dy = -HALF; dy <= HALF; dy++)
            for (int dx = -HALF; dx <= HALF; dx++) begin
                x = int'(ax) + dx;
                y = int'(ay) + dy;
                if (x >= 0 && x < (1 << AW) && y >= 0 && y < (1 << AW))
                    exp_q.push_back({y[AW-1:0], x[AW-1:0]});
            end
    endtask

    // Image-store model: answers after cur_dly waiting cycles, optionally strobes spuriously when idle.
    initial begin
        int wcnt;
        logic [2*AW-1:0] hold, got;
        wcnt = 0;
        hold = '0;
        pix.rec_data = 1'b0;
        pix.rec_data_vaild = 1'b0;
        forever begin
            @(negedge clk);
            if (pix.req_valid === 1'b1) begin
                got = {pix.req_adr_y, pix.req_adr_x};
                if (wcnt == 0) hold = got;
                else check("req_adr_stable", got, hold);
                if (wcnt >= cur_dly) begin
                    pix.rec_data_vaild = 1'b1;
                    pix.rec_data = is_hit(pix.req_adr_x, pix.req_adr_y);
                    acc_cnt++;
                    wcnt = 0;
                    if (exp_q.size() == 0) check("req_unexpected", got, 0);
                    else check("req_adr", got, exp_q.pop_front());
                end else begin
                    pix.rec_data_vaild = 1'b0;
                    pix.rec_data = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                pix.rec_data_vaild = cur_noise;
                pix.rec_data = cur_noise;
            end
        end
    end

    task automatic wait_coc(output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_start", busy, 1);
            if (coc_valid === 1'b1) break;
            if (lat > 2000) begin
                check("coc_timeout", 0, 1);
                lat = -1;
                break;
            end
        end
    endtask

    task automatic run_op(input int i);
        int lat;
        set_mode(vecs[i]);
        exp_q.delete();
        build_exp(vecs[i].ax, vecs[i].ay);
        acc_cnt = 0;
        @(negedge clk);
        enable = 1'b1; app_x = vecs[i].ax; app_y = vecs[i].ay;
        @(posedge clk);
        #1 enable = 1'b0;
        wait_coc(lat);
        check($sformatf("v%0d_latency", i), lat, vecs[i].elat);
        check($sformatf("v%0d_coc_x", i), coc_x, vecs[i].ex);
        check($sformatf("v%0d_coc_y", i), coc_y, vecs[i].ey);
        check($sformatf("v%0d_error", i), error, vecs[i].eerr);
        check($sformatf("v%0d_req_count", i), acc_cnt, vecs[i].ereq);
        check($sformatf("v%0d_req_left", i), exp_q.size(), 0);
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", i), busy, 0);
        check($sformatf("v%0d_strobe_1cyc", i), {coc_valid, error}, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_valid"}, pix.req_valid, 0);
        check({tag, "_req_adr"}, {pix.req_adr_y, pix.req_adr_x}, 0);
        check({tag, "_coc_valid"}, coc_valid, 0);
        check({tag, "_coc_adr"}, {coc_y, coc_x}, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        int lat;
        bit seen;
        //                ax   ay  all nh  h0x  h0y  h1x  h1y  h2x  h2y dly nz  ex   ey  err lat req
        vecs[0] = mk(100, 200, 1, 0,   0,   0,   0,   0,   0,   0, 0, 0, 100, 200, 0,  41, 25);
        vecs[1] = mk(100, 200, 0, 1, 101, 199,   0,   0,   0,   0, 0, 0, 101, 199, 0,  41, 25);
        vecs[2] = mk(100, 200, 0, 2, 100, 200, 101, 200,   0,   0, 0, 0, 101, 200, 0,  41, 25);
        vecs[3] = mk(100, 200, 0, 3, 100, 199, 100, 200, 101, 201, 0, 0, 100, 200, 0,  41, 25);
        vecs[4] = mk(100, 200, 0, 0,   0,   0,   0,   0,   0,   0, 0, 1, 100, 200, 1,  26, 25);
        vecs[5] = mk(  0,   0, 1, 0,   0,   0,   0,   0,   0,   0, 0, 1,   1,   1, 0,  41,  9);
        vecs[6] = mk(100, 200, 1, 0,   0,   0,   0,   0,   0,   0, 3, 0, 100, 200, 0, 116, 25);

        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 7; i++) run_op(i);

        // Back-to-back: enable held high restarts after exactly one IDLE cycle.
        set_mode(vecs[0]);
        exp_q.delete();
        build_exp(100, 200);
        build_exp(100, 200);
        acc_cnt = 0;
        @(negedge clk);
        enable = 1'b1; app_x = 10'd100; app_y = 10'd200;
        wait_coc(lat);
        check("b2b_first_latency", lat, 41);
        @(negedge clk);
        check("b2b_gap_busy", busy, 0);
        @(negedge clk);
        check("b2b_restart_busy", busy, 1);
        enable = 1'b0;
        wait_coc(lat);
        check("b2b_second_latency", lat, 40);
        check("b2b_coc", {coc_y, coc_x}, {10'd200, 10'd100});
        check("b2b_req_count", acc_cnt, 50);
        @(negedge clk);

        // Reset mid-scan under backpressure aborts with no result.
        set_mode(vecs[6]);
        exp_q.delete();
        build_exp(100, 200);
        @(negedge clk);
        enable = 1'b1; app_x = 10'd100; app_y = 10'd200;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_scanning", dbg_state, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check_zero_outputs("mid_rst");
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (coc_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abort_no_coc", seen, 0);
        run_op(6);

        // rst and enable together: reset wins.
        @(negedge clk);
        rst = 1'b1; enable = 1'b1;
        @(posedge clk);
        #1 check("rst_wins_busy", busy, 0);
        check("rst_wins_state", dbg_state, 0);
        @(negedge clk) begin rst = 1'b0; enable = 1'b0; end
        @(posedge clk);
        #1 check("rst_wins_stays_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
